cmd_dispatch: RTL and testbench
===============================

// Module: cmd_dispatch
// PURPOSE
//  Quadcopter-side command sequencer between UART_comm and the flight controller.
//  - Takes each command packet (cmd_rdy/cmd/data), clears it and decodes it.
//  - Updates setpoint registers, runs calibration or landing as commanded.
//  - Returns a one-byte response through the UART_comm send_resp/resp_sent handshake.
//  - Runs a link watchdog that forces an emergency land when the remote goes silent.
// PARAMETERS
//  TMO_W   26     watchdog counter width; timeout after 2^TMO_W-1 clks (~1.34 s @50MHz)
//  ACK     8'hA5  response byte for a recognised command
//  NAK     8'hEE  response byte for an unrecognised command
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  cmd_rdy      in   1   UART_comm: packet valid, held until clr_cmd_rdy
//  cmd          in   8   UART_comm: command byte
//  data         in   16  UART_comm: command payload
//  resp_sent    in   1   UART_comm: response byte fully transmitted
//  cal_done     in   1   inertial integrator: calibration complete
//  clr_cmd_rdy  out  1   1-clk pulse, knocks down cmd_rdy
//  send_resp    out  1   1-clk pulse, starts response transmit
//  resp         out  8   response byte, stable from send_resp until resp_sent
//  d_ptch       out  16  signed pitch setpoint
//  d_roll       out  16  signed roll setpoint
//  d_yaw        out  16  signed yaw setpoint
//  thrst        out  9   unsigned thrust setpoint
//  strt_cal     out  1   1-clk pulse, starts calibration
//  inertial_cal out  1   high while calibration is in progress
//  motors_off   out  1   high forces ESCs off
// BEHAVIOUR
//  Reset values:
//  - All setpoints 0; resp 0; all pulses 0; inertial_cal 0; motors_off 1.
//  - FSM in IDLE; watchdog counter 0.
//  - rst mid-operation aborts everything; no send_resp is issued afterwards.
//  Opcodes: 02 SET_PTCH, 03 SET_ROLL, 04 SET_YAW, 05 SET_THRST (data[8:0] only;
//   data[15:9] ignored), 06 CALIBRATE, 07 EMER_LAND, 08 MTRS_OFF.
//  FSM states: IDLE, EXEC, CAL, RESP, WAIT_SENT.
//  IDLE: cmd_rdy sampled high at clk N.
//   - cmd/data are latched at N.
//   - clr_cmd_rdy pulses at N+1; the FSM moves to EXEC at N+1.
//  EXEC (N+1):
//   - SET_*: register <= data. Next state RESP.
//   - EMER_LAND: ptch, roll, yaw and thrst <= 0. Next state RESP.
//   - MTRS_OFF: motors_off <= 1. Next state RESP.
//   - CALIBRATE: strt_cal pulses; inertial_cal <= 1; motors_off <= 0. Next state CAL.
//   - Unknown opcode: no register changes. Next state RESP with NAK.
//  CAL:
//   - Hold inertial_cal high until cal_done is sampled high.
//   - Then inertial_cal <= 0 and the FSM moves to RESP.
//   - No timeout in CAL itself; the watchdog still runs.
//  RESP: send_resp pulses and resp is driven (ACK, or NAK for an unknown opcode).
//   - For a SET command, send_resp lands at N+2.
//  WAIT_SENT:
//   - resp_sent is sampled starting the clk after send_resp.
//   - When resp_sent is 1, the FSM returns to IDLE.
//  cmd_rdy outside IDLE is not an error and is not lost.
//   - UART_comm holds cmd_rdy, so the packet is taken on the next IDLE cycle.
//  Watchdog:
//   - Counts up every clk in every state; cleared in the EXEC cycle of any accepted command.
//   - At all-ones: ptch, roll, yaw and thrst <= 0 (same effect as EMER_LAND).
//   - motors_off is unchanged and no response is sent.
//   - The counter saturates at all-ones and re-forces zeros each clk until the next command.
//   - If EXEC and saturation fall on the same clk, the command wins.
//   - Counter wrap-around is forbidden.
//  Only the targeted register changes on a SET; the other setpoints hold their value.
// TESTING (bench TMO_W=10)
//  1. SET_PTCH data=16'hFF80 -> clr_cmd_rdy at N+1, d_ptch=16'hFF80 at N+2,
//     send_resp at N+2 with resp=8'hA5; other setpoints still 0.
//  2. SET_THRST data=16'hFFFF -> thrst=9'h1FF; then EMER_LAND -> thrst=0, d_ptch=0, ACK.
//  3. CALIBRATE, cal_done raised 20 clks later -> strt_cal 1 pulse, inertial_cal high
//     for 20 clks, motors_off=0, send_resp 1 clk after cal_done.
//  4. cmd=8'h55 -> no register changes, resp=8'hEE; next SET_YAW=16'h0123 accepted.
//  5. Command, then silence for 1023 clks -> all setpoints 0 with no send_resp;
//     a SET_ROLL=16'h0040 afterwards clears the counter and d_roll holds 16'h0040.
//  6. rst asserted while in WAIT_SENT and while in CAL -> all outputs at reset values
//     next clk; no spurious send_resp; a new command is accepted normally.

Source files
------------

// File: rtl/cmd_dispatch.sv
// rtl/cmd_dispatch.sv - command sequencer between UART_comm and the flight controller
module cmd_dispatch #(
    parameter int         TMO_W = 26,
    parameter logic [7:0] ACK   = 8'hA5,
    parameter logic [7:0] NAK   = 8'hEE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        resp_sent,
    input  logic        cal_done,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic [7:0]  resp,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        strt_cal,
    output logic        inertial_cal,
    output logic        motors_off
);

    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    localparam logic [TMO_W-1:0] WDOG_MAX = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0] WDOG_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, EXEC, CAL, RESP, WAIT_SENT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [15:0]      data_q, data_d;
    logic [TMO_W-1:0] wdog_q, wdog_d;
    logic             clr_q, clr_d, send_q, send_d, strt_q, strt_d;
    logic             ical_q, ical_d, moff_q, moff_d;
    logic [7:0]       resp_q, resp_d;
    logic [15:0]      ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
    logic [8:0]       thrst_q, thrst_d;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        clr_d   = 1'b0;
        send_d  = 1'b0;
        strt_d  = 1'b0;
        ical_d  = ical_q;
        moff_d  = moff_q;
        resp_d  = resp_q;
        ptch_d  = ptch_q;
        roll_d  = roll_q;
        yaw_d   = yaw_q;
        thrst_d = thrst_q;
        wdog_d  = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + WDOG_ONE;

        // Saturated watchdog keeps re-landing every clk; an executing command overrides it.
        if (wdog_q == WDOG_MAX && state_q != EXEC) begin
            ptch_d  = '0;
            roll_d  = '0;
            yaw_d   = '0;
            thrst_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_rdy) begin
                    cmd_d   = cmd;
                    data_d  = data;
                    clr_d   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                wdog_d  = '0;
                resp_d  = ACK;
                send_d  = 1'b1;
                state_d = RESP;
                case (cmd_q)
                    SET_PTCH:  ptch_d  = data_q;
                    SET_ROLL:  roll_d  = data_q;
                    SET_YAW:   yaw_d   = data_q;
                    SET_THRST: thrst_d = data_q[8:0];
                    EMER_LAND: begin
                        ptch_d  = '0;
                        roll_d  = '0;
                        yaw_d   = '0;
                        thrst_d = '0;
                    end
                    MTRS_OFF:  moff_d  = 1'b1;
                    CALIBRATE: begin
                        send_d  = 1'b0;
                        strt_d  = 1'b1;
                        ical_d  = 1'b1;
                        moff_d  = 1'b0;
                        state_d = CAL;
                    end
                    default:   resp_d  = NAK;
                endcase
            end
            CAL: begin
                if (cal_done) begin
                    ical_d  = 1'b0;
                    send_d  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:      state_d = WAIT_SENT;
            WAIT_SENT: if (resp_sent) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            data_q  <= '0;
            wdog_q  <= '0;
            clr_q   <= 1'b0;
            send_q  <= 1'b0;
            strt_q  <= 1'b0;
            ical_q  <= 1'b0;
            moff_q  <= 1'b1;
            resp_q  <= '0;
            ptch_q  <= '0;
            roll_q  <= '0;
            yaw_q   <= '0;
            thrst_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            wdog_q  <= wdog_d;
            clr_q   <= clr_d;
            send_q  <= send_d;
            strt_q  <= strt_d;
            ical_q  <= ical_d;
            moff_q  <= moff_d;
            resp_q  <= resp_d;
            ptch_q  <= ptch_d;
            roll_q  <= roll_d;
            yaw_q   <= yaw_d;
            thrst_q <= thrst_d;
        end
    end

    assign clr_cmd_rdy  = clr_q;
    assign send_resp    = send_q;
    assign resp         = resp_q;
    assign d_ptch       = ptch_q;
    assign d_roll       = roll_q;
    assign d_yaw        = yaw_q;
    assign thrst        = thrst_q;
    assign strt_cal     = strt_q;
    assign inertial_cal = ical_q;
    assign motors_off   = moff_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb/tb_cmd_dispatch.sv - directed self-checking bench for cmd_dispatch
module tb_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_rdy = 1'b0;
    logic [7:0]  cmd = '0;
    logic [15:0] data = '0;
    logic        resp_sent = 1'b0;
    logic        cal_done = 1'b0;
    logic        clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off;
    logic [7:0]  resp;
    logic [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0]  thrst;

    int checks = 0;
    int errors = 0;
    logic       sr;
    logic [7:0] rp;

    cmd_dispatch #(.TMO_W(10)) dut (
        .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .resp_sent(resp_sent), .cal_done(cal_done), .clr_cmd_rdy(clr_cmd_rdy),
        .send_resp(send_resp), .resp(resp), .d_ptch(d_ptch), .d_roll(d_roll),
        .d_yaw(d_yaw), .thrst(thrst), .strt_cal(strt_cal),
        .inertial_cal(inertial_cal), .motors_off(motors_off)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] c, input logic [15:0] d);
        cmd_rdy = 1'b1;
        cmd     = c;
        data    = d;
        tick();
        cmd_rdy = 1'b0;
    endtask

    task automatic do_cmd(input logic [7:0] c, input logic [15:0] d);
        present(c, d);
        tick();
        sr = send_resp;
        rp = resp;
        tick();
        resp_sent = 1'b1;
        tick();
        resp_sent = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00001", {clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off});
        end
        checks++;
        if ({d_ptch, d_roll, d_yaw, thrst, resp} !== '0) begin
            errors++;
            $display("FAIL reset_regs got %h %h %h %h %h exp 0", d_ptch, d_roll, d_yaw, thrst, resp);
        end
    endtask

    task automatic test_set_ptch();
        present(8'h02, 16'hFF80);
        checks++;
        if (clr_cmd_rdy !== 1'b1 || send_resp !== 1'b0) begin
            errors++;
            $display("FAIL ptch_clr got clr=%b send=%b exp 1 0", clr_cmd_rdy, send_resp);
        end
        tick();
        checks++;
        if (d_ptch !== 16'hFF80 || send_resp !== 1'b1 || resp !== 8'hA5 || clr_cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL ptch_exec got ptch=%h send=%b resp=%h clr=%b exp ff80 1 a5 0", d_ptch, send_resp, resp, clr_cmd_rdy);
        end
        checks++;
        if ({d_roll, d_yaw, thrst} !== '0) begin
            errors++;
            $display("FAIL ptch_others got %h %h %h exp 0", d_roll, d_yaw, thrst);
        end
        tick();
        checks++;
        if (send_resp !== 1'b0 || resp !== 8'hA5) begin
            errors++;
            $display("FAIL ptch_pulse got send=%b resp=%h exp 0 a5", send_resp, resp);
        end
        resp_sent = 1'b1;
        tick();
        resp_sent = 1'b0;
    endtask

    task automatic test_thrst_land();
        do_cmd(8'h05, 16'hFFFF);
        checks++;
        if (thrst !== 9'h1FF || sr !== 1'b1 || rp !== 8'hA5 || d_ptch !== 16'hFF80) begin
            errors++;
            $display("FAIL thrst_set got thrst=%h send=%b resp=%h ptch=%h exp 1ff 1 a5 ff80", thrst, sr, rp, d_ptch);
        end
        do_cmd(8'h07, 16'h0000);
        checks++;
        if (thrst !== 9'h0 || d_ptch !== 16'h0 || rp !== 8'hA5 || motors_off !== 1'b1) begin
            errors++;
            $display("FAIL emer_land got thrst=%h ptch=%h resp=%h moff=%b exp 0 0 a5 1", thrst, d_ptch, rp, motors_off);
        end
    endtask

    task automatic test_calibrate();
        int ical_n = 0;
        int strt_n = 0;
        int send_n = 0;
        present(8'h06, 16'h0000);
        tick();
        checks++;
        if (strt_cal !== 1'b1 || inertial_cal !== 1'b1 || motors_off !== 1'b0 || send_resp !== 1'b0) begin
            errors++;
            $display("FAIL cal_start got strt=%b ical=%b moff=%b send=%b exp 1 1 0 0", strt_cal, inertial_cal, motors_off, send_resp);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            ical_n += int'(inertial_cal);
            strt_n += int'(strt_cal);
            send_n += int'(send_resp);
        end
        checks++;
        if (ical_n !== 20 || strt_n !== 0 || send_n !== 0) begin
            errors++;
            $display("FAIL cal_hold got ical=%0d strt=%0d send=%0d exp 20 0 0", ical_n, strt_n, send_n);
        end
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        checks++;
        if (send_resp !== 1'b1 || inertial_cal !== 1'b0 || resp !== 8'hA5 || motors_off !== 1'b0) begin
            errors++;
            $display("FAIL cal_done got send=%b ical=%b resp=%h moff=%b exp 1 0 a5 0", send_resp, inertial_cal, resp, motors_off);
        end
        tick();
        resp_sent = 1'b1;
        tick();
        resp_sent = 1'b0;
        do_cmd(8'h08, 16'h0000);
        checks++;
        if (motors_off !== 1'b1 || rp !== 8'hA5) begin
            errors++;
            $display("FAIL mtrs_off got moff=%b resp=%h exp 1 a5", motors_off, rp);
        end
    endtask

    task automatic test_unknown();
        do_cmd(8'h03, 16'h0011);
        do_cmd(8'h55, 16'hABCD);
        checks++;
        if (sr !== 1'b1 || rp !== 8'hEE) begin
            errors++;
            $display("FAIL nak_resp got send=%b resp=%h exp 1 ee", sr, rp);
        end
        checks++;
        if (d_roll !== 16'h0011 || d_ptch !== 16'h0 || d_yaw !== 16'h0 || thrst !== 9'h0) begin
            errors++;
            $display("FAIL nak_regs got %h %h %h %h exp 0011 0 0 0", d_roll, d_ptch, d_yaw, thrst);
        end
        do_cmd(8'h04, 16'h0123);
        checks++;
        if (d_yaw !== 16'h0123 || rp !== 8'hA5 || d_roll !== 16'h0011) begin
            errors++;
            $display("FAIL yaw_after_nak got yaw=%h resp=%h roll=%h exp 0123 a5 0011", d_yaw, rp, d_roll);
        end
    endtask

    task automatic test_back_to_back();
        present(8'h02, 16'h1234);
        tick();
        cmd_rdy = 1'b1;
        cmd     = 8'h04;
        data    = 16'h0777;
        tick();
        tick();
        checks++;
        if (clr_cmd_rdy !== 1'b0 || d_yaw !== 16'h0123) begin
            errors++;
            $display("FAIL b2b_held got clr=%b yaw=%h exp 0 0123", clr_cmd_rdy, d_yaw);
        end
        resp_sent = 1'b1;
        tick();
        resp_sent = 1'b0;
        tick();
        cmd_rdy = 1'b0;
        checks++;
        if (clr_cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_take got clr=%b exp 1", clr_cmd_rdy);
        end
        tick();
        checks++;
        if (d_yaw !== 16'h0777 || d_ptch !== 16'h1234 || send_resp !== 1'b1) begin
            errors++;
            $display("FAIL b2b_exec got yaw=%h ptch=%h send=%b exp 0777 1234 1", d_yaw, d_ptch, send_resp);
        end
        tick();
        resp_sent = 1'b1;
        tick();
        resp_sent = 1'b0;
    endtask

    task automatic test_watchdog();
        int send_n = 0;
        do_cmd(8'h05, 16'h0080);
        for (int i = 0; i < 990; i++) begin
            tick();
            send_n += int'(send_resp);
        end
        checks++;
        if (d_ptch !== 16'h1234 || d_yaw !== 16'h0777 || thrst !== 9'h080 || d_roll !== 16'h0011) begin
            errors++;
            $display("FAIL wdog_early got %h %h %h %h exp 1234 0777 080 0011", d_ptch, d_yaw, thrst, d_roll);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            send_n += int'(send_resp);
        end
        checks++;
        if ({d_ptch, d_roll, d_yaw, thrst} !== '0 || send_n !== 0 || motors_off !== 1'b1) begin
            errors++;
            $display("FAIL wdog_land got %h %h %h %h send=%0d moff=%b exp 0 0 0 0 0 1", d_ptch, d_roll, d_yaw, thrst, send_n, motors_off);
        end
        do_cmd(8'h03, 16'h0040);
        for (int i = 0; i < 100; i++) tick();
        checks++;
        if (d_roll !== 16'h0040 || sr !== 1'b1 || rp !== 8'hA5) begin
            errors++;
            $display("FAIL wdog_clear got roll=%h send=%b resp=%h exp 0040 1 a5", d_roll, sr, rp);
        end
    endtask

    task automatic test_reset_midop();
        int send_n = 0;
        present(8'h06, 16'h0000);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({strt_cal, inertial_cal, motors_off, send_resp} !== 4'b0010 || d_roll !== 16'h0) begin
            errors++;
            $display("FAIL rst_cal got %b roll=%h exp 0010 0000", {strt_cal, inertial_cal, motors_off, send_resp}, d_roll);
        end
        cal_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            send_n += int'(send_resp);
        end
        cal_done = 1'b0;
        present(8'h02, 16'h0055);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (d_ptch !== 16'h0 || resp !== 8'h0 || send_resp !== 1'b0 || clr_cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait got ptch=%h resp=%h send=%b clr=%b exp 0 0 0 0", d_ptch, resp, send_resp, clr_cmd_rdy);
        end
        resp_sent = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            send_n += int'(send_resp) + int'(clr_cmd_rdy);
        end
        resp_sent = 1'b0;
        checks++;
        if (send_n !== 0) begin
            errors++;
            $display("FAIL rst_spurious got %0d pulses exp 0", send_n);
        end
        do_cmd(8'h04, 16'h0042);
        checks++;
        if (d_yaw !== 16'h0042 || sr !== 1'b1 || rp !== 8'hA5) begin
            errors++;
            $display("FAIL rst_recover got yaw=%h send=%b resp=%h exp 0042 1 a5", d_yaw, sr, rp);
        end
    endtask

    initial begin
        test_reset();
        test_set_ptch();
        test_thrst_land();
        test_calibrate();
        test_unknown();
        test_back_to_back();
        test_watchdog();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
